// File: rtl/sme_pkg.sv
// Shared types and constants for the SME stimulus/response driver.
package sme_pkg;

    localparam int STR_MAX_C = 32;
    localparam int PAT_MAX_C = 8;
    localparam int IDX_W     = 5;
    localparam int CHAR_W    = 8;

    typedef logic [CHAR_W-1:0] char_t;

    typedef enum logic [2:0] {
        IDLE,
        SEND_STR,
        SEND_PAT,
        WAIT,
        REPORT
    } sme_drv_state_t;

endpackage

// File: rtl/sme_driver_if.sv
// Character/result bus between the driver (master) and the SME core (slave).
interface sme_driver_if;
    import sme_pkg::*;

    char_t             chardata;
    logic              isstring;
    logic              ispattern;
    logic              valid;
    logic              match;
    logic [IDX_W-1:0]  match_index;

    modport master (
        output chardata, isstring, ispattern,
        input  valid, match, match_index
    );

    modport slave (
        input  chardata, isstring, ispattern,
        output valid, match, match_index
    );

endinterface

// File: rtl/sme_char_buf.sv
// Append-only character buffer with length tracking and random read.
module sme_char_buf
    import sme_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic          wr_first,
    input  char_t         wr_data,
    input  logic [AW-1:0] rd_addr,
    output char_t         rd_data,
    output logic [LW-1:0] len
);

    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    char_t mem [DEPTH];

    // Length tracking: a first byte restarts at 1, appends saturate at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            len <= '0;
        end else if (wr_en) begin
            if (wr_first) begin
                len <= LW'(1);
            end else if (len != FULL) begin
                len <= len + LW'(1);
            end
        end
    end

    // Storage: contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_first) begin
                mem[0] <= wr_data;
            end else if (len != FULL) begin
                mem[len[AW-1:0]] <= wr_data;
            end
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sme_driver.sv
// Loads a string and pattern, streams them to the SME core, checks its result.
module sme_driver
    import sme_pkg::*;
#(
    parameter int STR_MAX = STR_MAX_C,
    parameter int PAT_MAX = PAT_MAX_C,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_valid,
    input  logic              ld_sel,
    input  logic              ld_first,
    input  char_t             ld_data,
    output logic              ld_ready,
    input  logic              start,
    input  logic              send_str,
    input  logic              exp_match,
    input  logic [IDX_W-1:0]  exp_index,
    output logic              busy,
    sme_driver_if.master      sme,
    output logic              res_valid,
    output logic              res_match,
    output logic [IDX_W-1:0]  res_index,
    output logic              res_pass,
    output logic              res_timeout,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  run_cnt
);

    localparam int SW  = $clog2(STR_MAX);
    localparam int SLW = $clog2(STR_MAX + 1);
    localparam int PW  = $clog2(PAT_MAX);
    localparam int PLW = $clog2(PAT_MAX + 1);
    localparam int TW  = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    sme_drv_state_t    state;
    logic [SW-1:0]     ptr;
    logic [SW-1:0]     rd_ptr;
    logic [TW-1:0]     timer;
    logic              exp_match_q;
    logic [IDX_W-1:0]  exp_index_q;
    logic [SLW-1:0]    str_len;
    logic [PLW-1:0]    pat_len;
    char_t             str_rd;
    char_t             pat_rd;
    logic              ld_we;
    logic              start_ok;
    logic              last_str;
    logic              last_pat;
    logic              got_pass;

    assign ld_we    = ld_valid & ld_ready;
    // In IDLE the read port points at char 0 so the first char can be
    // registered on the same edge that accepts start.
    assign rd_ptr   = (state == IDLE) ? '0 : ptr;
    assign start_ok = start && (pat_len != '0) && (!send_str || (str_len != '0));
    assign last_str = (SLW'(ptr) == str_len - SLW'(1));
    assign last_pat = (PLW'(ptr[PW-1:0]) == pat_len - PLW'(1));
    assign got_pass = (sme.match == exp_match_q) &&
                      (!exp_match_q || (sme.match_index == exp_index_q));

    sme_char_buf #(.DEPTH(STR_MAX)) u_str_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (ld_we & ~ld_sel),
        .wr_first (ld_first),
        .wr_data  (ld_data),
        .rd_addr  (rd_ptr),
        .rd_data  (str_rd),
        .len      (str_len)
    );

    sme_char_buf #(.DEPTH(PAT_MAX)) u_pat_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (ld_we & ld_sel),
        .wr_first (ld_first),
        .wr_data  (ld_data),
        .rd_addr  (rd_ptr[PW-1:0]),
        .rd_data  (pat_rd),
        .len      (pat_len)
    );

    // Run FSM: serializes buffers, waits for result, scores it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            timer         <= '0;
            exp_match_q   <= 1'b0;
            exp_index_q   <= '0;
            ld_ready      <= 1'b0;
            busy          <= 1'b0;
            sme.chardata  <= '0;
            sme.isstring  <= 1'b0;
            sme.ispattern <= 1'b0;
            res_valid     <= 1'b0;
            res_match     <= 1'b0;
            res_index     <= '0;
            res_pass      <= 1'b0;
            res_timeout   <= 1'b0;
            pass_cnt      <= '0;
            run_cnt       <= '0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    ld_ready <= 1'b1;
                    if (start_ok) begin
                        exp_match_q <= exp_match;
                        exp_index_q <= exp_index;
                        res_timeout <= 1'b0;
                        ld_ready    <= 1'b0;
                        busy        <= 1'b1;
                        timer       <= '0;
                        // Char 0 goes out on this edge; ptr advances as if
                        // one SEND cycle already elapsed.
                        if (send_str) begin
                            sme.chardata  <= str_rd;
                            sme.isstring  <= 1'b1;
                            sme.ispattern <= 1'b0;
                            ptr           <= (str_len == SLW'(1)) ? '0 : SW'(1);
                            state         <= (str_len == SLW'(1)) ? SEND_PAT : SEND_STR;
                        end else begin
                            sme.chardata  <= pat_rd;
                            sme.isstring  <= 1'b0;
                            sme.ispattern <= 1'b1;
                            ptr           <= SW'(1);
                            state         <= (pat_len == PLW'(1)) ? WAIT : SEND_PAT;
                        end
                    end
                end
                SEND_STR: begin
                    sme.chardata  <= str_rd;
                    sme.isstring  <= 1'b1;
                    sme.ispattern <= 1'b0;
                    if (last_str) begin
                        ptr   <= '0;
                        state <= SEND_PAT;
                    end else begin
                        ptr <= ptr + SW'(1);
                    end
                end
                SEND_PAT: begin
                    sme.chardata  <= pat_rd;
                    sme.isstring  <= 1'b0;
                    sme.ispattern <= 1'b1;
                    if (last_pat) begin
                        timer <= '0;
                        state <= WAIT;
                    end else begin
                        ptr <= ptr + SW'(1);
                    end
                end
                WAIT: begin
                    sme.isstring  <= 1'b0;
                    sme.ispattern <= 1'b0;
                    timer         <= timer + 1'b1;
                    if (sme.valid || (timer == T_LAST)) begin
                        res_valid   <= 1'b1;
                        res_match   <= sme.valid ? sme.match : 1'b0;
                        res_index   <= sme.valid ? sme.match_index : '0;
                        res_pass    <= sme.valid && got_pass;
                        res_timeout <= !sme.valid;
                        if (run_cnt != '1) begin
                            run_cnt <= run_cnt + 1'b1;
                        end
                        if (sme.valid && got_pass && (pass_cnt != '1)) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    ptr      <= '0;
                    busy     <= 1'b0;
                    ld_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sme_driver.sv
// Directed self-checking bench for sme_driver.
module tb_sme_driver;
    import sme_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              ld_valid, ld_sel, ld_first;
    char_t             ld_data;
    logic              ld_ready;
    logic              start, send_str, exp_match;
    logic [IDX_W-1:0]  exp_index;
    logic              busy;
    logic              res_valid, res_match, res_pass, res_timeout;
    logic [IDX_W-1:0]  res_index;
    logic [15:0]       pass_cnt, run_cnt;

    int tests = 0;
    int fails = 0;

    sme_driver_if sme ();

    sme_driver #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .ld_valid    (ld_valid),
        .ld_sel      (ld_sel),
        .ld_first    (ld_first),
        .ld_data     (ld_data),
        .ld_ready    (ld_ready),
        .start       (start),
        .send_str    (send_str),
        .exp_match   (exp_match),
        .exp_index   (exp_index),
        .busy        (busy),
        .sme         (sme),
        .res_valid   (res_valid),
        .res_match   (res_match),
        .res_index   (res_index),
        .res_pass    (res_pass),
        .res_timeout (res_timeout),
        .pass_cnt    (pass_cnt),
        .run_cnt     (run_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic sel, input string s);
        for (int i = 0; i < s.len(); i++) begin
            ld_valid = 1'b1;
            ld_sel   = sel;
            ld_first = (i == 0);
            ld_data  = s[i];
            step();
        end
        ld_valid = 1'b0;
        ld_first = 1'b0;
    endtask

    task automatic do_start(input logic ss, input logic em, input logic [IDX_W-1:0] ei);
        start     = 1'b1;
        send_str  = ss;
        exp_match = em;
        exp_index = ei;
        step();
        start = 1'b0;
    endtask

    // Waits dly cycles, pulses valid, then checks the result report.
    task automatic respond(input int dly, input logic m, input logic [IDX_W-1:0] idx,
                           input logic xpass, input int xpc, input int xrc);
        repeat (dly) step();
        sme.valid       = 1'b1;
        sme.match       = m;
        sme.match_index = idx;
        step();
        sme.valid = 1'b0;
        chk("res_valid", res_valid, 1);
        chk("res_match", res_match, m);
        chk("res_index", res_index, idx);
        chk("res_pass", res_pass, xpass);
        chk("res_timeout", res_timeout, 0);
        chk("pass_cnt", pass_cnt, xpc);
        chk("run_cnt", run_cnt, xrc);
        step();
        chk("res_valid_pulse", res_valid, 0);
        chk("busy_done", busy, 0);
    endtask

    initial begin
        string s1, p1, p2, longs;
        int k;
        logic seen;
        s1 = "abcdefg";
        p1 = "cde";
        p2 = "xy";
        longs = "";
        for (int i = 0; i < 35; i++) longs = {longs, string'(8'h41 + 8'(i))};

        reset = 1'b1; ld_valid = 0; ld_sel = 0; ld_first = 0; ld_data = '0;
        start = 0; send_str = 0; exp_match = 0; exp_index = '0;
        sme.valid = 0; sme.match = 0; sme.match_index = '0;
        repeat (3) step();
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_chardata", sme.chardata, 0);
        chk("rst_isstring", sme.isstring, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_run_cnt", run_cnt, 0);
        reset = 1'b0;
        step();
        chk("idle_ld_ready", ld_ready, 1);

        // start with nothing loaded is ignored
        do_start(1'b0, 1'b0, '0);
        chk("empty_start_busy", busy, 0);
        chk("empty_start_ispattern", sme.ispattern, 0);

        // pattern present but empty string with send_str=1 is ignored
        load(1'b1, p1);
        do_start(1'b1, 1'b0, '0);
        chk("nostr_start_busy", busy, 0);
        chk("nostr_start_isstring", sme.isstring, 0);

        // run 1: string + pattern, expected match at 2
        load(1'b0, s1);
        do_start(1'b1, 1'b1, 5'd2);
        chk("run1_busy", busy, 1);
        chk("run1_ld_ready", ld_ready, 0);
        for (int i = 0; i < 7; i++) begin
            chk("run1_isstring", sme.isstring, 1);
            chk("run1_ispattern_s", sme.ispattern, 0);
            chk("run1_str_char", sme.chardata, s1[i]);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk("run1_ispattern", sme.ispattern, 1);
            chk("run1_isstring_p", sme.isstring, 0);
            chk("run1_pat_char", sme.chardata, p1[i]);
            step();
        end
        chk("run1_wait_ispattern", sme.ispattern, 0);
        chk("run1_wait_hold", sme.chardata, "e");
        respond(2, 1'b1, 5'd2, 1'b1, 1, 1);

        // run 2: pattern only, no match expected, index ignored
        load(1'b1, p2);
        do_start(1'b0, 1'b0, 5'd3);
        for (int i = 0; i < 2; i++) begin
            chk("run2_isstring", sme.isstring, 0);
            chk("run2_pat_char", sme.chardata, p2[i]);
            step();
        end
        respond(1, 1'b0, 5'd7, 1'b1, 2, 2);

        // run 3: wrong index reported
        do_start(1'b0, 1'b1, 5'd4);
        repeat (2) step();
        respond(0, 1'b1, 5'd5, 1'b0, 2, 3);

        // run 4: no response, timeout after 16 WAIT cycles
        do_start(1'b0, 1'b0, '0);
        step();
        chk("run4_last_pat", sme.chardata, "y");
        k = 0;
        while (!res_valid && k < 40) begin
            step();
            k++;
        end
        chk("run4_timeout_latency", k, 16);
        chk("run4_res_timeout", res_timeout, 1);
        chk("run4_res_pass", res_pass, 0);
        chk("run4_res_match", res_match, 0);
        chk("run4_res_index", res_index, 0);
        chk("run4_run_cnt", run_cnt, 4);
        chk("run4_pass_cnt", pass_cnt, 2);
        step();

        // run 5: 35 chars loaded, only 32 kept and sent
        load(1'b0, longs);
        do_start(1'b1, 1'b0, '0);
        chk("run5_timeout_cleared", res_timeout, 0);
        for (int i = 0; i < 32; i++) begin
            chk("run5_isstring", sme.isstring, 1);
            chk("run5_str_char", sme.chardata, longs[i]);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            chk("run5_ispattern", sme.ispattern, 1);
            chk("run5_pat_char", sme.chardata, p2[i]);
            step();
        end
        respond(0, 1'b0, 5'd0, 1'b1, 3, 5);

        // reset during SEND_PAT aborts the run
        do_start(1'b1, 1'b0, '0);
        repeat (32) step();
        chk("abort_in_pat", sme.ispattern, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_ispattern", sme.ispattern, 0);
        chk("abort_isstring", sme.isstring, 0);
        chk("abort_chardata", sme.chardata, 0);
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_pass", res_pass, 0);
        chk("abort_run_cnt", run_cnt, 0);
        chk("abort_pass_cnt", pass_cnt, 0);
        step();
        chk("abort_ld_ready", ld_ready, 1);
        seen = 1'b0;
        sme.valid = 1'b1;
        sme.match = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            sme.valid = 1'b0;
            if (res_valid || busy) seen = 1'b1;
        end
        chk("abort_no_report", seen, 0);
        chk("abort_run_cnt_after", run_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
